window_motor_actuator: RTL and testbench
========================================

# window_motor_actuator

Motor-side responder for the push-button window controller. It consumes the single-cycle `Open_CW` / `Close_CCW` command pulses and drives the window motor clockwise or counter-clockwise until the matching limit switch trips. It enforces a dead time on direction reversal and flags a fault when travel exceeds a cycle budget. It sits between the window controller FSM and the motor H-bridge.

## Interface
- `TRAVEL_CYCLES`, default 1000: maximum motor-on cycles per run before fault; counter width is `$clog2(TRAVEL_CYCLES+1)`.
- `DEAD_CYCLES`, default 4 (must be ≥1): motor-off cycles inserted on reversal.
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `Open_CW`  in  1  one-cycle command: open the window (drive CW).
- `Close_CCW`  in  1  one-cycle command: close the window (drive CCW).
- `limit_open`  in  1  high when the window is fully open (already synchronous to `clock`).
- `limit_closed`  in  1  high when the window is fully closed (already synchronous to `clock`).
- `motor_cw`  out  1  H-bridge CW drive.
- `motor_ccw`  out  1  H-bridge CCW drive.
- `busy`  out  1  high in RUN_CW, RUN_CCW and DEAD.
- `fault`  out  1  sticky; high in FAULT.

## Operation
- States: IDLE, RUN_CW, RUN_CCW, DEAD, FAULT.
- All outputs are registered and Moore-decoded from state.
- Reset value of every output: 0. The state resets to IDLE, the counter to 0, and the pending direction to CW.
- `motor_cw` and `motor_ccw` are never high in the same cycle, in any state.
- IDLE:
  - `Open_CW` alone with `limit_open`=0 goes to RUN_CW.
  - `Close_CCW` alone with `limit_closed`=0 goes to RUN_CCW.
  - A command toward an already-asserted limit is ignored.
  - `Open_CW` and `Close_CCW` both high in the same cycle are both ignored.
- RUN_CW:
  - `limit_open`=1 goes to IDLE.
  - `Close_CCW`=1 (and no limit) goes to DEAD with pending direction CCW.
  - `Open_CW` is ignored.
  - If the counter reaches `TRAVEL_CYCLES` with no limit, go to FAULT.
- RUN_CCW: mirror of RUN_CW, using `limit_closed` and `Open_CW`.
- Priority in RUN states: the limit switch wins over the timeout, and the timeout wins over a reversal command.
- DEAD:
  - Motors are off for exactly `DEAD_CYCLES` cycles, then the block enters RUN in the pending direction with the counter cleared.
  - If the pending-direction limit is already high at DEAD exit, go to IDLE instead.
  - Commands during DEAD are ignored.
- FAULT: motors off, `fault`=1, all commands ignored; only `reset` exits.
- `limit_open` and `limit_closed` both high in any state other than FAULT goes to FAULT next cycle. This check has the highest priority.
- Counter: clears on entry to each RUN state and increments every RUN cycle. It never wraps; the FAULT transition occurs first.
- Reset asserted mid-run: motors drop immediately (asynchronously) to 0 and the block returns to IDLE.

## Timing
- A command sampled at edge N causes the motor output to rise after edge N+1 (latency 1).
- A limit sampled high at edge N drops the motor output after edge N+1.
- Timeout: the motor output is high for exactly `TRAVEL_CYCLES` cycles. `fault` rises in the same cycle the motor output falls.
- Reversal: the old drive falls, then there are `DEAD_CYCLES` cycles with both drives low, then the new drive rises.
- `busy` is aligned with state; it is low in IDLE and FAULT.

## Test plan
All scenarios use `TRAVEL_CYCLES`=20 and `DEAD_CYCLES`=3.
- **Reset:** assert `reset` mid-run → all outputs read 0 immediately. After release, `Open_CW` pulse → `motor_cw`=1 one cycle later.
- **Normal open:** `Open_CW` pulse, raise `limit_open` 8 cycles later → `motor_cw` high exactly 9 cycles, then `busy`=0 and `fault`=0.
- **Reversal:**
  - Stimulus: in RUN_CW at cycle 5, pulse `Close_CCW`.
  - Required: `motor_cw` falls, then 3 cycles with both drives 0, then `motor_ccw` rises.
  - Follow-up: raise `limit_closed` → `motor_ccw` drops next cycle.
- **Timeout:** `Close_CCW` with no limit ever → `motor_ccw` high 20 cycles, then `fault`=1 sticky. A subsequent `Open_CW` is ignored until `reset`.
- **Ignored commands:**
  - `Open_CW` while `limit_open`=1 → no motion.
  - `Open_CW` and `Close_CCW` in the same cycle in IDLE → no motion.
  - `Open_CW` during DEAD → no effect.
- **Both limits:** `limit_open`=`limit_closed`=1 during RUN_CW → FAULT next cycle with both drives 0. A random command sequence never produces both drives high in the same cycle.

Source files
------------

// File: rtl/window_motor_actuator.sv
// ---------------------------------------------------------------------------
// window_motor_actuator
//
// Motor-side responder for the push-button window controller. Turns the
// one-cycle open/close command pulses into a held H-bridge drive that runs
// until the matching limit switch trips. It inserts a dead time on direction
// reversal and latches a fault when a run exceeds its cycle budget or both
// limit switches read high together.
//
// Ports
//   clock         in   system clock, rising edge
//   reset         in   asynchronous, active-high reset
//   Open_CW       in   one-cycle command: open the window (drive CW)
//   Close_CCW     in   one-cycle command: close the window (drive CCW)
//   limit_open    in   window fully open (synchronous to clock)
//   limit_closed  in   window fully closed (synchronous to clock)
//   motor_cw      out  H-bridge CW drive
//   motor_ccw     out  H-bridge CCW drive
//   busy          out  high while running or in dead time
//   fault         out  sticky fault, cleared only by reset
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | motor off, waiting for a command
// S_RUN_CW  | driving CW (opening) until limit_open or timeout
// S_RUN_CCW | driving CCW (closing) until limit_closed or timeout
// S_DEAD    | both drives off between reversal directions
// S_FAULT   | motor off, fault latched until reset
//
// All outputs are registered decodes of the current state, so they follow
// the state register by one clock. The async reset still clears them at
// once.
// ---------------------------------------------------------------------------
module window_motor_actuator #(
    parameter int TRAVEL_CYCLES = 1000,
    parameter int DEAD_CYCLES   = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic Open_CW,
    input  logic Close_CCW,
    input  logic limit_open,
    input  logic limit_closed,
    output logic motor_cw,
    output logic motor_ccw,
    output logic busy,
    output logic fault
);

    localparam int CNT_W  = $clog2(TRAVEL_CYCLES + 1);
    localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);

    // The counter shows the number of RUN cycles already completed, so the
    // run that is in its last allowed cycle sees TRAVEL_CYCLES-1.
    localparam logic [CNT_W-1:0]  C_TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [DEAD_W-1:0] C_DEAD_LOAD   = DEAD_W'(DEAD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN_CW,
        S_RUN_CCW,
        S_DEAD,
        S_FAULT
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DEAD_W-1:0]   r_dead;
    logic                r_pend_ccw;
    logic                r_motor_cw;
    logic                r_motor_ccw;
    logic                r_busy;
    logic                r_fault;

    logic w_both_lim;
    logic w_pend_lim;

    assign w_both_lim = limit_open & limit_closed;
    assign w_pend_lim = r_pend_ccw ? limit_closed : limit_open;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_dead      <= '0;
            r_pend_ccw  <= 1'b0;
            r_motor_cw  <= 1'b0;
            r_motor_ccw <= 1'b0;
            r_busy      <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_motor_cw  <= (r_state == S_RUN_CW);
            r_motor_ccw <= (r_state == S_RUN_CCW);
            r_busy      <= (r_state == S_RUN_CW) || (r_state == S_RUN_CCW) ||
                           (r_state == S_DEAD);
            r_fault     <= (r_state == S_FAULT);

            case (r_state)
                S_IDLE: begin
                    if (w_both_lim) begin
                        r_state <= S_FAULT;
                    end else if (Open_CW && !Close_CCW && !limit_open) begin
                        r_state <= S_RUN_CW;
                        r_cnt   <= '0;
                    end else if (Close_CCW && !Open_CW && !limit_closed) begin
                        r_state <= S_RUN_CCW;
                        r_cnt   <= '0;
                    end
                end

                // Priority: both limits, own limit, timeout, reversal.
                S_RUN_CW: begin
                    if (w_both_lim) begin
                        r_state <= S_FAULT;
                    end else if (limit_open) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == C_TRAVEL_LAST) begin
                        r_state <= S_FAULT;
                    end else if (Close_CCW) begin
                        r_state    <= S_DEAD;
                        r_pend_ccw <= 1'b1;
                        r_dead     <= C_DEAD_LOAD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_RUN_CCW: begin
                    if (w_both_lim) begin
                        r_state <= S_FAULT;
                    end else if (limit_closed) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == C_TRAVEL_LAST) begin
                        r_state <= S_FAULT;
                    end else if (Open_CW) begin
                        r_state    <= S_DEAD;
                        r_pend_ccw <= 1'b0;
                        r_dead     <= C_DEAD_LOAD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // Down-counter loaded with DEAD_CYCLES-1 gives exactly
                // DEAD_CYCLES cycles in this state.
                S_DEAD: begin
                    if (w_both_lim) begin
                        r_state <= S_FAULT;
                    end else if (r_dead == '0) begin
                        r_cnt <= '0;
                        if (w_pend_lim) begin
                            r_state <= S_IDLE;
                        end else if (r_pend_ccw) begin
                            r_state <= S_RUN_CCW;
                        end else begin
                            r_state <= S_RUN_CW;
                        end
                    end else begin
                        r_dead <= r_dead - 1'b1;
                    end
                end

                S_FAULT: begin
                    r_state <= S_FAULT;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign motor_cw  = r_motor_cw;
    assign motor_ccw = r_motor_ccw;
    assign busy      = r_busy;
    assign fault     = r_fault;

endmodule

// File: tb/tb_window_motor_actuator.sv
module tb_window_motor_actuator;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic Open_CW = 1'b0;
    logic Close_CCW = 1'b0;
    logic limit_open = 1'b0;
    logic limit_closed = 1'b0;
    logic motor_cw, motor_ccw, busy, fault;

    int n_cmp = 0;
    int n_err = 0;

    window_motor_actuator #(.TRAVEL_CYCLES(20), .DEAD_CYCLES(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .Open_CW      (Open_CW),
        .Close_CCW    (Close_CCW),
        .limit_open   (limit_open),
        .limit_closed (limit_closed),
        .motor_cw     (motor_cw),
        .motor_ccw    (motor_ccw),
        .busy         (busy),
        .fault        (fault)
    );

    always #5 clock = ~clock;

    // exp = {motor_cw, motor_ccw, busy, fault}
    task automatic chk(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {motor_cw, motor_ccw, busy, fault};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Pulse lasts one cycle; returns at the negedge after the sampling edge.
    task automatic cmd_open();
        Open_CW = 1'b1;
        step(1);
        Open_CW = 1'b0;
    endtask

    task automatic cmd_close();
        Close_CCW = 1'b1;
        step(1);
        Close_CCW = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    int hi;
    logic [3:0] snap [0:24];

    initial begin
        // reset state
        step(2);
        chk("reset_state", 4'b0000);
        reset = 1'b0;
        step(1);

        // reset mid-run drops everything at once
        cmd_open();
        chk("open_latency_pre", 4'b0000);
        step(1);
        chk("open_running", 4'b1010);
        step(3);
        reset = 1'b1;
        #1;
        chk("async_reset_mid_run", 4'b0000);
        step(1);
        reset = 1'b0;
        step(1);
        cmd_open();
        step(1);
        chk("open_after_reset", 4'b1010);
        limit_open = 1'b1;
        step(1);
        chk("limit_lag", 4'b1010);
        step(1);
        chk("limit_stop", 4'b0000);

        // open toward an asserted limit is ignored
        cmd_open();
        step(2);
        chk("open_at_limit_ignored", 4'b0000);
        limit_open = 1'b0;
        step(1);

        // normal open: limit sampled 9 edges after the command edge
        cmd_open();
        hi = 0;
        for (int i = 0; i < 15; i++) begin
            if (i == 8) limit_open = 1'b1;
            step(1);
            hi += int'(motor_cw);
        end
        chk_int("normal_open_cw_cycles", hi, 9);
        chk("normal_open_done", 4'b0000);
        limit_open = 1'b0;
        step(1);

        // reversal with Open_CW during dead time
        cmd_open();
        step(4);
        chk("rev_pre", 4'b1010);
        cmd_close();
        chk("rev_cw_still_on", 4'b1010);
        step(1);
        chk("rev_dead1", 4'b0010);
        Open_CW = 1'b1;
        step(1);
        Open_CW = 1'b0;
        chk("rev_dead2", 4'b0010);
        step(1);
        chk("rev_dead3", 4'b0010);
        step(1);
        chk("rev_ccw_on", 4'b0110);
        limit_closed = 1'b1;
        step(1);
        chk("rev_limit_lag", 4'b0110);
        step(1);
        chk("rev_ccw_off", 4'b0000);
        limit_closed = 1'b0;
        step(1);

        // timeout
        cmd_close();
        hi = 0;
        for (int i = 0; i < 25; i++) begin
            step(1);
            snap[i] = {motor_cw, motor_ccw, busy, fault};
            hi += int'(motor_ccw);
        end
        chk_int("timeout_ccw_cycles", hi, 20);
        chk_int("timeout_last_run", int'(snap[19]), int'(4'b0110));
        chk_int("timeout_fault_edge", int'(snap[20]), int'(4'b0001));
        cmd_open();
        step(3);
        chk("fault_sticky", 4'b0001);
        do_reset();
        chk("fault_cleared", 4'b0000);

        // simultaneous commands in IDLE
        Open_CW = 1'b1;
        Close_CCW = 1'b1;
        step(1);
        Open_CW = 1'b0;
        Close_CCW = 1'b0;
        step(2);
        chk("both_cmds_ignored", 4'b0000);

        // both limits during RUN_CW
        cmd_open();
        step(2);
        chk("bothlim_pre", 4'b1010);
        limit_open = 1'b1;
        limit_closed = 1'b1;
        step(1);
        chk("bothlim_lag", 4'b1010);
        step(1);
        chk("bothlim_fault", 4'b0001);
        limit_open = 1'b0;
        limit_closed = 1'b0;
        do_reset();

        // random commands: drives never both high
        for (int i = 0; i < 400; i++) begin
            Open_CW      = ($urandom_range(0, 3) == 0);
            Close_CCW    = ($urandom_range(0, 3) == 0);
            limit_open   = ($urandom_range(0, 9) == 0);
            limit_closed = ($urandom_range(0, 9) == 0);
            reset        = ((i % 50) == 49);
            step(1);
            chk_int("drives_exclusive", int'(motor_cw & motor_ccw), 0);
        end
        reset = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
